// File: rtl/fc_result_writer.sv
// FC layer back end: round, shift, optional ReLU and saturate each accumulator
// result, then scatter the bytes across SRAM e0~e4 in the next layer's layout.
module fc_result_writer #(
  parameter int DATA_WIDTH             = 8,
  parameter int ACC_WIDTH              = 32,
  parameter int SHIFT                  = 8,
  parameter int DATA_NUM_PER_SRAM_ADDR = 4,
  parameter int BANK_NUM               = 5,
  parameter int ADDR_WIDTH             = 10
) (
  input  logic                              clk,
  input  logic                              srst,
  input  logic                              start,
  input  logic [9:0]                        out_num,
  input  logic                              relu_en,
  input  logic                              in_valid,
  input  logic [ACC_WIDTH-1:0]              in_data,
  output logic                              in_ready,
  output logic                              sram_write_enable_e0,
  output logic                              sram_write_enable_e1,
  output logic                              sram_write_enable_e2,
  output logic                              sram_write_enable_e3,
  output logic                              sram_write_enable_e4,
  output logic [DATA_NUM_PER_SRAM_ADDR-1:0] sram_bytemask_e,
  output logic [ADDR_WIDTH-1:0]             sram_waddr_e,
  output logic [DATA_WIDTH-1:0]             sram_wdata_e,
  output logic                              busy,
  output logic                              done
);

  localparam int STAGES = 2;
  localparam int CW     = 10;
  localparam int LW     = (DATA_NUM_PER_SRAM_ADDR > 1) ? $clog2(DATA_NUM_PER_SRAM_ADDR) : 1;
  localparam int BW     = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;

  localparam logic [LW-1:0] LANE_LAST = LW'(DATA_NUM_PER_SRAM_ADDR - 1);
  localparam logic [BW-1:0] BANK_LAST = BW'(BANK_NUM - 1);

  localparam logic signed [ACC_WIDTH:0] RND  = {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [ACC_WIDTH:0] MAXV = {{(ACC_WIDTH + 2 - DATA_WIDTH){1'b0}},
                                                {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] MINV = ~MAXV;

  localparam logic [DATA_NUM_PER_SRAM_ADDR-1:0] LANE0_OH = {1'b1, {(DATA_NUM_PER_SRAM_ADDR-1){1'b0}}};
  localparam logic [BANK_NUM-1:0]               BANK0_OH = {{(BANK_NUM-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]  out_num_r;
  logic [CW-1:0]  acc_cnt;
  logic           relu_r;
  logic           fire;
  logic           start_ok;
  logic [STAGES:1] vld_pipe;

  logic signed [ACC_WIDTH:0] acc_ext, rnd_sum, rnd_shr;
  logic signed [ACC_WIDTH:0] s1, clip;

  logic [LW-1:0]          lane_cnt;
  logic [BW-1:0]          bank_cnt;
  logic [ADDR_WIDTH-1:0]  waddr_cnt;
  logic [DATA_NUM_PER_SRAM_ADDR-1:0] lane_oh_r;
  logic [BANK_NUM-1:0]    bank_oh_r;
  logic [BANK_NUM-1:0]    we_n;
  logic [ADDR_WIDTH-1:0]  waddr_r;
  logic [DATA_WIDTH-1:0]  wdata_r;

  assign fire     = in_valid & in_ready;
  assign start_ok = start & (state == IDLE);

  // ---------------------------------------------------------------- control
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (out_num == '0) ? DONE : RUN;
      RUN:   if (fire && (acc_cnt + 1'b1) == out_num_r) state_nxt = FLUSH;
      // Only stage 1 matters: the output stage drains in the same cycle we leave.
      FLUSH: if (!vld_pipe[1]) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state     <= IDLE;
      acc_cnt   <= '0;
      out_num_r <= '0;
      relu_r    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        out_num_r <= out_num;
        relu_r    <= relu_en;
        acc_cnt   <= '0;
      end else if (fire) begin
        acc_cnt <= acc_cnt + 1'b1;
      end
    end
  end

  assign in_ready = (state == RUN);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // ---------------------------------------------------------------- stage 1
  // Round half up: add half an LSB of the shifted result, then floor-shift.
  always_comb begin
    acc_ext = {in_data[ACC_WIDTH-1], in_data};
    rnd_sum = acc_ext + RND;
    rnd_shr = rnd_sum >>> SHIFT;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      vld_pipe <= '0;
      s1       <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], fire};
      if (fire) s1 <= rnd_shr;
    end
  end

  // ---------------------------------------------------------------- stage 2
  always_comb begin
    clip = s1;
    if (relu_r && s1[ACC_WIDTH]) clip = '0;
    if (clip > MAXV)      clip = MAXV;
    else if (clip < MINV) clip = MINV;
  end

  // lane/bank/waddr counters track the index of the next byte to be written
  always_ff @(posedge clk) begin
    if (srst) begin
      lane_cnt  <= '0;
      bank_cnt  <= '0;
      waddr_cnt <= '0;
      lane_oh_r <= '0;
      bank_oh_r <= '0;
      waddr_r   <= '0;
      wdata_r   <= '0;
    end else if (start_ok) begin
      lane_cnt  <= '0;
      bank_cnt  <= '0;
      waddr_cnt <= '0;
    end else if (vld_pipe[1]) begin
      lane_oh_r <= LANE0_OH >> lane_cnt;
      bank_oh_r <= BANK0_OH << bank_cnt;
      waddr_r   <= waddr_cnt;
      wdata_r   <= clip[DATA_WIDTH-1:0];
      if (lane_cnt == LANE_LAST) begin
        lane_cnt <= '0;
        if (bank_cnt == BANK_LAST) begin
          bank_cnt  <= '0;
          waddr_cnt <= waddr_cnt + 1'b1;
        end else begin
          bank_cnt <= bank_cnt + 1'b1;
        end
      end else begin
        lane_cnt <= lane_cnt + 1'b1;
      end
    end
  end

  // strobes are gated by the output-stage valid so they last exactly one cycle
  assign we_n            = ~(bank_oh_r & {BANK_NUM{vld_pipe[2]}});
  assign sram_bytemask_e = ~(lane_oh_r & {DATA_NUM_PER_SRAM_ADDR{vld_pipe[2]}});
  assign sram_waddr_e    = waddr_r;
  assign sram_wdata_e    = wdata_r;

  assign sram_write_enable_e0 = we_n[0];
  assign sram_write_enable_e1 = we_n[1];
  assign sram_write_enable_e2 = we_n[2];
  assign sram_write_enable_e3 = we_n[3];
  assign sram_write_enable_e4 = we_n[4];

endmodule

// File: tb/tb_fc_result_writer.sv
// Scoreboard bench for fc_result_writer: expected writes are queued at each
// accepted transfer and matched against the SRAM strobes as they appear.
module tb_fc_result_writer;

  logic        clk = 1'b0;
  logic        srst, start, relu_en, in_valid;
  logic [9:0]  out_num;
  logic [31:0] in_data;
  logic        in_ready, busy, done;
  logic        e0, e1, e2, e3, e4;
  logic [3:0]  mask;
  logic [9:0]  waddr;
  logic [7:0]  wdata;

  fc_result_writer dut (
    .clk(clk), .srst(srst), .start(start), .out_num(out_num), .relu_en(relu_en),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .sram_write_enable_e0(e0), .sram_write_enable_e1(e1), .sram_write_enable_e2(e2),
    .sram_write_enable_e3(e3), .sram_write_enable_e4(e4),
    .sram_bytemask_e(mask), .sram_waddr_e(waddr), .sram_wdata_e(wdata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [4:0] we;
    logic [3:0] mask;
    logic [9:0] waddr;
    logic [7:0] wdata;
  } exp_t;

  exp_t sb[$];
  int   vals[$];
  int   cyc = 0;
  int   n_cmp = 0, n_err = 0;
  int   m_k = 0, wr_cnt = 0, last_wr = 0;
  bit   m_relu = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int x, input bit relu);
    longint v;
    v = (longint'(x) + 128) >>> 8;
    if (relu && v < 0) v = 0;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return v[7:0];
  endfunction

  // monitor: check strobes, then record any transfer happening at the next edge
  always @(negedge clk) begin
    logic [4:0] we_v;
    exp_t       e;
    int         word;
    we_v = {e4, e3, e2, e1, e0};
    if (we_v != 5'h1f || mask != 4'hf) begin
      wr_cnt++;
      last_wr = cyc;
      if (sb.size() == 0) chk("spurious_wr", 1, 0);
      else begin
        e = sb.pop_front();
        chk("wr_cyc",   cyc,   e.cyc);
        chk("wr_we",    we_v,  e.we);
        chk("wr_mask",  mask,  e.mask);
        chk("wr_waddr", waddr, e.waddr);
        chk("wr_wdata", wdata, e.wdata);
      end
    end
    if (srst) sb.delete();
    else if (in_valid && in_ready) begin
      word    = m_k / 4;
      e.cyc   = cyc + 2;
      e.we    = ~(5'b00001 << (word % 5));
      e.mask  = ~(4'b1000 >> (m_k % 4));
      e.waddr = 10'(word / 5);
      e.wdata = exp_byte($signed(in_data), m_relu);
      sb.push_back(e);
      m_k++;
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_ready", in_ready, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_we",    {e4, e3, e2, e1, e0}, 5'h1f);
    chk("rst_mask",  mask, 4'hf);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
  endtask

  task automatic begin_layer(input int n, input bit relu);
    @(posedge clk); #1;
    start = 1'b1; out_num = 10'(n); relu_en = relu;
    m_relu = relu; m_k = 0;
    @(negedge clk);
    chk("start_idle_busy", busy, 0);
    chk("start_idle_done", done, 0);
    @(posedge clk); #1;
    // later changes must not affect the running layer
    start = 1'b0; out_num = 10'($urandom); relu_en = ~relu;
  endtask

  task automatic xfer(input int d, input bit gaps, input bit spur);
    bit ok;
    int tmo;
    if (gaps) repeat ($urandom_range(0, 2)) begin in_valid = 1'b0; @(posedge clk); #1; end
    in_valid = 1'b1; in_data = d; start = spur;
    ok = 1'b0; tmo = 0;
    while (!ok && tmo < 20) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1; start = 1'b0; tmo++;
    end
    if (!ok) chk("xfer_timeout", 0, 1);
  endtask

  task automatic run_layer(input int n, input bit relu, input bit gaps, input bit spur);
    int  w0, sc;
    bit  seen;
    w0 = wr_cnt;
    begin_layer(n, relu);
    sc = cyc - 1;
    for (int i = 0; i < n; i++) xfer(vals[i], gaps, spur && (i == n / 2));
    in_valid = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 60 && !seen; t++) begin @(negedge clk); seen = done; end
    chk("done_seen", seen, 1);
    if (n == 0) chk("done_cyc_empty", cyc, sc + 1);
    else        chk("done_cyc", cyc, last_wr + 1);
    chk("busy_in_done", busy, 1);
    chk("wr_count", wr_cnt - w0, n);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    int w0;
    bit any_done;
    srst = 1'b1; start = 1'b0; out_num = '0; relu_en = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1; srst = 1'b0;

    // valid in IDLE must be ignored
    w0 = wr_cnt;
    in_valid = 1'b1; in_data = 32'd5000;
    repeat (4) @(posedge clk);
    #1; in_valid = 1'b0;
    @(negedge clk);
    chk("idle_valid_ready", in_ready, 0);
    chk("idle_valid_nowr", wr_cnt - w0, 0);

    vals = {4736};
    run_layer(1, 1'b0, 1'b0, 1'b0);
    vals = {100000, -300, -40000};
    run_layer(3, 1'b0, 1'b0, 1'b0);
    run_layer(3, 1'b1, 1'b0, 1'b0);

    vals.delete();
    for (int i = 0; i < 24; i++) vals.push_back(int'($urandom_range(0, 200000)) - 100000);
    run_layer(24, 1'b0, 1'b0, 1'b0);
    run_layer(24, 1'b1, 1'b1, 1'b1);

    run_layer(0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("empty_busy_off", busy, 0);

    // reset in the middle of a 10-result layer
    vals.delete();
    for (int i = 0; i < 10; i++) vals.push_back(i * 1000 - 3000);
    begin_layer(10, 1'b0);
    for (int i = 0; i < 5; i++) xfer(vals[i], 1'b0, 1'b0);
    srst = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk_reset_outputs();
    any_done = 1'b0;
    repeat (8) begin @(negedge clk); any_done |= done; end
    chk("no_done_after_rst", any_done, 0);

    vals = {1280, -1280};
    run_layer(2, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
